// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the SimpleRISC fetch stage and the IF/OF pipeline latch.
// Imported by the fetch stage, the latch and the downstream decode logic.
package fetch_stage_pkg;

  localparam int unsigned InstW = 32;

  // SimpleRISC nop: opcode 01101 in bits [31:27], all other fields zero.
  localparam logic [InstW-1:0] NopInsn = 32'h6800_0000;

  typedef enum logic {
    StFetch,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/if_of_latch.sv
// Pipeline latch holding {valid, pc, inst}; flush forces a NOP bubble and wins over load.
// With neither load nor flush asserted the contents are held.
module if_of_latch
  import fetch_stage_pkg::*;
#(
  parameter int unsigned      PC_W     = 32,
  parameter logic [InstW-1:0] NOP_INSN = NopInsn
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [InstW-1:0] inst_i,
  output logic             valid_o,
  output logic [PC_W-1:0]  pc_o,
  output logic [InstW-1:0] inst_o
);

  logic             valid_q;
  logic [PC_W-1:0]  pc_q;
  logic [InstW-1:0] inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INSN;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INSN;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack fetch FSM with a one-entry skid buffer,
// and branch/stall priority logic driving the IF/OF latch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned      PC_W     = 32,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [InstW-1:0] NOP_INSN = NopInsn
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [InstW-1:0] imem_rdata,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  branch_pc_i,
  output logic             if_of_valid,
  output logic [PC_W-1:0]  if_of_pc,
  output logic [InstW-1:0] if_of_inst
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  skid_pc_q;
  logic [InstW-1:0] skid_inst_q;
  logic             skid_load;
  logic             lat_load, lat_flush;
  logic [PC_W-1:0]  lat_pc;
  logic [InstW-1:0] lat_inst;
  logic             fetch_ack;

  assign imem_req  = (state_q == StFetch) & ~rst;
  assign imem_addr = pc_q;
  assign fetch_ack = (state_q == StFetch) & imem_ack;

  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    skid_load = 1'b0;
    lat_load  = 1'b0;
    lat_flush = 1'b0;
    lat_pc    = pc_q;
    lat_inst  = imem_rdata;
    if (branch_taken_i) begin
      // Redirect discards any same-cycle ack and the skid contents.
      pc_d      = branch_pc_i;
      state_d   = StFetch;
      lat_flush = 1'b1;
    end else if (state_q == StHold) begin
      if (!stall_i) begin
        lat_load = 1'b1;
        lat_pc   = skid_pc_q;
        lat_inst = skid_inst_q;
        state_d  = StFetch;
      end
    end else if (fetch_ack) begin
      pc_d = pc_q + PC_W'(4);
      if (stall_i) begin
        skid_load = 1'b1;
        state_d   = StHold;
      end else begin
        lat_load = 1'b1;
      end
    end else if (!stall_i) begin
      lat_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (skid_load) begin
        skid_pc_q   <= pc_q;
        skid_inst_q <= imem_rdata;
      end
    end
  end

  if_of_latch #(
    .PC_W    (PC_W),
    .NOP_INSN(NOP_INSN)
  ) u_if_of_latch (
    .clk    (clk),
    .rst    (rst),
    .load_i (lat_load),
    .flush_i(lat_flush),
    .pc_i   (lat_pc),
    .inst_i (lat_inst),
    .valid_o(if_of_valid),
    .pc_o   (if_of_pc),
    .inst_o (if_of_inst)
  );

endmodule
